// File: rtl/fpu_issue_seq.sv
// fpu_issue_seq: issue sequencer for the shared multi-cycle FPU.
// Accepts one OP-FP instruction from ID, times its execution latency,
// performs the FP register-file writeback and stalls ID on structural,
// RAW and WAW hazards against the single pending destination register.
module fpu_issue_seq #(
    parameter int LAT_ADD  = 3,
    parameter int LAT_MUL  = 4,
    parameter int LAT_DIV  = 16,
    parameter int LAT_SQRT = 20,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_fp_valid,
    input  logic [4:0] id_funct5,
    input  logic [4:0] id_rd,
    input  logic       id_rd_fp,
    input  logic [4:0] id_rs1,
    input  logic       id_rs1_fp,
    input  logic [4:0] id_rs2,
    input  logic       id_rs2_fp,
    input  logic       ex_flush,
    input  logic       wb_ready,
    output logic       fpu_start,
    output logic [4:0] fpu_op,
    output logic       wb_fp_we,
    output logic [4:0] wb_rd,
    output logic       stall,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [4:0]       op_q;
    logic [4:0]       pend_rd;
    logic             start_q;
    logic             accept;
    logic             raw_hit;
    logic             waw_hit;

    // Counter load value: latency minus one, so EXEC lasts exactly LAT cycles.
    function automatic logic [CNT_W-1:0] lat_minus1(input logic [4:0] f5);
        int lat;
        case (f5)
            5'b00000, 5'b00001: lat = LAT_ADD;
            5'b00010:           lat = LAT_MUL;
            5'b00011:           lat = LAT_DIV;
            5'b01011:           lat = LAT_SQRT;
            default:            lat = 1;
        endcase
        return CNT_W'(lat - 1);
    endfunction

    // A flush in the same cycle kills the ID instruction before it can issue.
    assign accept = (state == IDLE) & id_fp_valid & ~ex_flush;

    // State, counter and the latched op/destination of the in-flight instruction.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            pend_rd <= '0;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            start_q <= accept;
            if (accept) begin
                op_q    <= id_funct5;
                pend_rd <= id_rd;
            end
        end
    end

    // Next-state and counter update; the counter only moves during EXEC.
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = EXEC;
                    cnt_nxt   = lat_minus1(id_funct5);
                end
            end
            EXEC: begin
                if (cnt == '0) state_nxt = WB;
                else           cnt_nxt   = cnt - 1'b1;
            end
            WB: begin
                if (wb_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Hazard compare against the pending destination; f0 is an ordinary FP register.
    always_comb begin
        raw_hit = (id_rs1_fp & (id_rs1 == pend_rd)) | (id_rs2_fp & (id_rs2 == pend_rd));
        waw_hit = id_rd_fp & (id_rd == pend_rd);
    end

    // Outputs are decoded from state so reset clears them immediately.
    always_comb begin
        busy      = (state != IDLE);
        fpu_start = start_q & (state == EXEC);
        fpu_op    = (state == EXEC) ? op_q : 5'd0;
        wb_fp_we  = (state == WB) & wb_ready;
        wb_rd     = (state == WB) ? pend_rd : 5'd0;
        stall     = busy & (id_fp_valid | raw_hit | waw_hit);
    end

endmodule

// File: doc/fpu_issue_seq.md
Name: fpu_issue_seq

Overview:
- Issue sequencer for the shared multi-cycle FPU in the RV32IF core.
- Accepts one decoded FP arithmetic instruction (OP-FP, opcode[6:2]=10100) from ID and starts the FPU.
- Counts a per-operation latency, then drives the FP register-file writeback.
- Tracks the single pending destination register and stalls ID on structural, RAW and WAW hazards against it.

Parameters:
LAT_ADD, 3, EXEC cycles for FADD/FSUB
LAT_MUL, 4, EXEC cycles for FMUL
LAT_DIV, 16, EXEC cycles for FDIV
LAT_SQRT, 20, EXEC cycles for FSQRT
CNT_W, 5, latency counter width; every LAT must be in 1..2^CNT_W

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
id_fp_valid  in  1  ID holds an OP-FP instruction
id_funct5  in  5  inst[31:27] of the ID instruction
id_rd  in  5  ID destination register index
id_rd_fp  in  1  ID instruction writes the FP regfile (OP-FP or FLW)
id_rs1  in  5  ID source 1 index
id_rs1_fp  in  1  source 1 is read from the FP regfile
id_rs2  in  5  ID source 2 index
id_rs2_fp  in  1  source 2 is read from the FP regfile
ex_flush  in  1  ID instruction is being killed this cycle
wb_ready  in  1  FP writeback port is free this cycle
fpu_start  out  1  one-cycle start pulse to the FPU
fpu_op  out  5  funct5 of the in-flight op; 0 outside EXEC
wb_fp_we  out  1  FP regfile write enable
wb_rd  out  5  FP writeback destination register
stall  out  1  hold IF/ID
busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state, mid-op included):
  - state=IDLE; counter=0; pend_rd=0.
  - All outputs 0 immediately. No pending writeback survives reset.
- Latency decode from id_funct5:
  - 00000/00001 -> LAT_ADD; 00010 -> LAT_MUL; 00011 -> LAT_DIV; 01011 -> LAT_SQRT.
  - All other codes -> 1.
- accept = (state==IDLE) & id_fp_valid & ~ex_flush.
- On accept:
  - Latch op=id_funct5 and pend_rd=id_rd.
  - Load counter=LAT-1.
  - Next state EXEC.
- IDLE -> EXEC:
  - fpu_start=1 only in the first EXEC cycle.
  - fpu_op=latched op for every EXEC cycle.
- EXEC:
  - Counter decrements each cycle. On the cycle counter==0, next state WB.
  - EXEC lasts exactly LAT cycles.
- WB:
  - wb_rd=pend_rd; wb_fp_we=wb_ready.
  - If wb_ready, next state IDLE. Otherwise hold WB with wb_fp_we=0 and no timeout.
  - Exactly one wb_fp_we pulse per accepted op.
- Timing: accept at cycle T -> fpu_start at T+1 -> earliest wb_fp_we at T+LAT+1 -> IDLE at T+LAT+2.
- Back-to-back issue: no accept while in WB, including the cycle wb_fp_we fires. The next accept is earliest at T+LAT+2.
- stall is combinational, with busy=(state!=IDLE). It is the OR of:
  - structural: busy & id_fp_valid;
  - RAW: busy & ((id_rs1_fp & id_rs1==pend_rd) | (id_rs2_fp & id_rs2==pend_rd));
  - WAW: busy & id_rd_fp & id_rd==pend_rd.
- f0 is a real FP register and gets no zero-register exemption. Integer-side sources (*_fp=0) never match.
- stall is 0 in IDLE. The instruction being accepted does not stall.
- ex_flush:
  - Suppresses accept only. stall is still computed normally.
  - An accepted op is past ID and always runs to writeback. Flush in EXEC/WB has no effect.
- Simultaneous accept and ex_flush: flush wins, no accept, state stays IDLE.
- Counter never wraps: it is reloaded only on accept and held at 0 in WB/IDLE.

Test Plan:
- FADD f3 (funct5 00000, rd=3) accepted at T, wb_ready=1 -> fpu_start=1 only at T+1; fpu_op=0 over T+1..T+3; wb_fp_we=1, wb_rd=3 at T+4; busy=0 at T+5.
- FDIV f5 accepted at T, then ID FADD with id_rs2=5, id_rs2_fp=1 -> stall=1 from T+1 through T+17; FADD accepted at T+18 with fpu_start at T+19.
- FMUL f7 with wb_ready=0 for the first 2 WB cycles -> WB held over T+5..T+7; single wb_fp_we pulse at T+7; stall=1 throughout.
- id_fp_valid=1 with ex_flush=1 in IDLE -> no fpu_start and busy stays 0. ex_flush pulsed mid-EXEC of FADD -> writeback still at T+4.
- rst asserted when FSQRT counter=10 -> fpu_op, busy, stall and wb_fp_we drop to 0 asynchronously. A fresh FADD after release completes with normal T+4 timing.
- Pending rd=0 (FSUB f0): ID FLW f0 (id_rd_fp=1, id_rd=0) -> stall=1. ID integer ADD with rs1=0, id_rs1_fp=0 -> stall=0.
